proc_sequencer: RTL



---
 rtl/proc_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/proc_sequencer.sv
// proc_sequencer: fetch / issue / wait-for-Done sequencer for the 16-bit core.
// Optional single-step mode: define PROC_SEQ_SINGLE_STEP_EN (Step input, PAUSE state).

module proc_sequencer #(
    parameter int AW         = 8,
    parameter int START_ADDR = 0,
    parameter int TIMEOUT    = 15
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    input  logic          Stop,
`ifdef PROC_SEQ_SINGLE_STEP_EN
    input  logic          Step,
`endif
    output logic [AW-1:0] mem_addr,
    input  logic [15:0]   mem_rdata,
    output logic [15:0]   DIN,
    output logic          Run,
    input  logic          Done,
    output logic          Busy,
    output logic          Halted,
    output logic          Error,
    output logic [AW-1:0] PC,
    output logic [15:0]   InstrCount
);

    localparam logic [AW-1:0] START_PC = AW'(START_ADDR);
    localparam logic [7:0]    WD_LIMIT = 8'(TIMEOUT);
    localparam logic [2:0]    OP_HALT  = 3'b111;

`ifdef PROC_SEQ_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MEM,
        S_ISSUE,
        S_EXEC,
        S_HALTED,
        S_ERROR,
        S_PAUSE
    } state_t;
    localparam state_t S_RETIRE = S_PAUSE;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MEM,
        S_ISSUE,
        S_EXEC,
        S_HALTED,
        S_ERROR
    } state_t;
    localparam state_t S_RETIRE = S_FETCH;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   din_q, din_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    wd_q, wd_d;
    logic          stop_q, stop_d;

    logic          halt_word;
    logic [7:0]    wd_inc;
    logic [15:0]   cnt_inc;
    logic          stop_seen;

    assign halt_word = (mem_rdata[15:13] == OP_HALT);
    assign wd_inc    = wd_q + 8'd1;
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign stop_seen = stop_q | Stop;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            din_q   <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        stop_d  = stop_q;
        unique case (state_q)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (Start) begin
                    state_d = S_FETCH;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                    wd_d    = '0;
                    stop_d  = 1'b0;
                end
            end
            S_FETCH: begin
                state_d = S_MEM;
            end
            S_MEM: begin
                din_d = mem_rdata;
                if (halt_word) begin
                    state_d = S_HALTED;
                end else if (Stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ISSUE;
                    stop_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                // An issued instruction always runs to completion.
                state_d = S_EXEC;
                wd_d    = '0;
                stop_d  = Stop;
            end
            S_EXEC: begin
                stop_d = stop_seen;
                if (Done) begin
                    pc_d    = pc_q + 1'b1;
                    cnt_d   = cnt_inc;
                    wd_d    = '0;
                    state_d = stop_seen ? S_IDLE : S_RETIRE;
                end else begin
                    wd_d = wd_inc;
                    if (wd_inc == WD_LIMIT) begin
                        state_d = S_ERROR;
                    end
                end
            end
`ifdef PROC_SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (Stop) begin
                    state_d = S_IDLE;
                end else if (Step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr   = pc_q;
    assign PC         = pc_q;
    assign DIN        = din_q;
    assign InstrCount = cnt_q;
    assign Run        = (state_q == S_ISSUE);
    assign Halted     = (state_q == S_HALTED);
    assign Error      = (state_q == S_ERROR);
    assign Busy       = (state_q == S_FETCH) || (state_q == S_MEM) ||
                        (state_q == S_ISSUE) || (state_q == S_EXEC);

endmodule
